// File: rtl/vram_wctrl.sv
// rtl/vram_wctrl.sv - AXI4 write master streaming one frame from a FWFT FIFO into VRAM
// Fixed 32-beat x 4-byte INCR bursts, one burst outstanding at a time.
module vram_wctrl #(
  parameter int unsigned FRAME_BYTES = 1228800  // nonzero multiple of 128
) (
  input  logic        ACLK,
  input  logic        ARST,
  output logic [31:0] AWADDR,
  output logic [7:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY,
  input  logic        CAPSTART,
  input  logic        CAPON,
  input  logic [29:0] CAPADDR,
  input  logic [31:0] FIFODATA,
  input  logic        FIFOREADY,
  output logic        FIFORD,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  typedef enum logic [2:0] {HALT, WAITFIFO, SETADDR, WRITING, WAITRESP} state_t;

  localparam logic [29:0] FRAME_END = 30'(FRAME_BYTES);

  state_t      state;
  logic [2:0]  sync_ff;
  logic [29:0] base;
  logic [29:0] addrcnt;
  logic [4:0]  beatcnt;
  logic        awvalid_r;
  logic        wvalid_r;
  logic        bready_r;
  logic        err_r;
  logic        start;
  logic        last_burst;

  // CAPSTART is asynchronous; only a rising edge seen after the synchronizer starts a frame.
  assign start      = CAPON & (sync_ff[2:1] == 2'b01);
  assign last_burst = (addrcnt == FRAME_END);

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state     <= HALT;
      sync_ff   <= 3'b000;
      base      <= '0;
      addrcnt   <= '0;
      beatcnt   <= '0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[1:0], CAPSTART};
      case (state)
        HALT: begin
          if (start) begin
            base    <= CAPADDR;
            addrcnt <= '0;
            err_r   <= 1'b0;
            state   <= WAITFIFO;
          end
        end
        WAITFIFO: begin
          if (FIFOREADY) begin
            awvalid_r <= 1'b1;
            state     <= SETADDR;
          end
        end
        SETADDR: begin
          if (AWREADY) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b1;
            addrcnt   <= addrcnt + 30'h80;
            state     <= WRITING;
          end
        end
        WRITING: begin
          if (WREADY) begin
            if (beatcnt == 5'd31) begin
              beatcnt  <= '0;
              wvalid_r <= 1'b0;
              bready_r <= 1'b1;
              state    <= WAITRESP;
            end else begin
              beatcnt <= beatcnt + 5'd1;
            end
          end
        end
        WAITRESP: begin
          // An error response is recorded but the frame keeps going.
          if (BVALID) begin
            bready_r <= 1'b0;
            if (BRESP != 2'b00) err_r <= 1'b1;
            state <= last_burst ? HALT : WAITFIFO;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

  assign AWADDR  = {2'b00, base + addrcnt};
  assign AWLEN   = 8'd31;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign AWVALID = awvalid_r;
  assign WDATA   = FIFODATA;
  assign WSTRB   = 4'hF;
  assign WVALID  = wvalid_r;
  assign WLAST   = wvalid_r & (beatcnt == 5'd31);
  assign BREADY  = bready_r;
  assign FIFORD  = wvalid_r & WREADY;
  assign BUSY    = (state != HALT);
  assign DONE    = bready_r & BVALID & last_burst;
  assign ERR     = err_r;

endmodule

// File: tb/tb_vram_wctrl.sv
// tb/tb_vram_wctrl.sv - directed table-driven bench for vram_wctrl
// Uses an 8-burst frame so every scenario stays short.
module tb_vram_wctrl;

  localparam int FB = 1024;
  localparam int NB = FB / 128;

  logic        ACLK;
  logic        ARST;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        CAPSTART;
  logic        CAPON;
  logic [29:0] CAPADDR;
  logic [31:0] FIFODATA;
  logic        FIFOREADY;
  logic        FIFORD;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  vram_wctrl #(.FRAME_BYTES(FB)) dut (
    .ACLK(ACLK), .ARST(ARST),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .CAPSTART(CAPSTART), .CAPON(CAPON), .CAPADDR(CAPADDR),
    .FIFODATA(FIFODATA), .FIFOREADY(FIFOREADY), .FIFORD(FIFORD),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [29:0] capaddr;
    logic        capon;
    logic        stall;
    int          err_burst;
    int          exp_bursts;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_beats;
    int          exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  int n_cmp = 0;
  int n_fail = 0;

  // monitor state
  logic        stall_en = 1'b0;
  int          err_burst = 0;
  logic [29:0] exp_base = '0;
  int cyc, aw_cnt, beats, fiford_cnt, wl_cnt, b_cnt, bbeat, done_cnt;
  int addr_errs, stab_errs, wv_errs, wdata_errs, wlast_errs, outst_errs, done_errs;
  int aw_cyc [2];
  logic [31:0] first_addr, last_addr, prev_addr;
  logic in_flight, w_ok, prev_awv, prev_awhs, err_pend, done_pend, awv_any;
  logic err_before, err_after;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc();
    @(negedge ACLK);
    #2;
  endtask

  task automatic reset_mon();
    cyc = 0; aw_cnt = 0; beats = 0; fiford_cnt = 0; wl_cnt = 0; b_cnt = 0; bbeat = 0;
    done_cnt = 0; addr_errs = 0; stab_errs = 0; wv_errs = 0; wdata_errs = 0;
    wlast_errs = 0; outst_errs = 0; done_errs = 0;
    aw_cyc[0] = 0; aw_cyc[1] = 0;
    first_addr = '0; last_addr = '0; prev_addr = '0;
    in_flight = 0; w_ok = 0; prev_awv = 0; prev_awhs = 0; err_pend = 0; done_pend = 0;
    awv_any = 0; err_before = 0; err_after = 0;
    BRESP = 2'b00;
  endtask

  // Ready generator: all ready, or AWREADY/WREADY each low with 30% probability.
  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      if (stall_en) begin
        AWREADY = ($urandom_range(0, 99) >= 30);
        WREADY  = ($urandom_range(0, 99) >= 30);
      end else begin
        AWREADY = 1'b1;
        WREADY  = 1'b1;
      end
    end
  end

  // Protocol monitor and reference model of the burst sequence.
  initial begin
    logic [29:0] ea;
    forever begin
      @(negedge ACLK);
      if (!ARST) begin
        cyc++;
        if (err_pend) begin err_after = ERR; err_pend = 0; end
        if (done_pend) begin if (BUSY) done_errs++; done_pend = 0; end
        if (AWVALID) awv_any = 1;
        if (prev_awv && !prev_awhs && (!AWVALID || AWADDR !== prev_addr)) stab_errs++;
        if (WVALID && !w_ok) wv_errs++;
        if (WDATA !== FIFODATA) wdata_errs++;
        if (WLAST !== (WVALID && bbeat == 31)) wlast_errs++;
        if (FIFORD) fiford_cnt++;
        if (AWVALID && AWREADY) begin
          ea = exp_base + 30'(aw_cnt * 128);
          if (in_flight) outst_errs++;
          if (AWADDR !== {2'b00, ea}) addr_errs++;
          if (aw_cnt == 0) first_addr = AWADDR;
          last_addr = AWADDR;
          if (aw_cnt < 2) aw_cyc[aw_cnt] = cyc;
          aw_cnt++;
          in_flight = 1;
          w_ok = 1;
        end
        if (WVALID && WREADY) begin
          beats++;
          if (bbeat == 31) begin bbeat = 0; w_ok = 0; wl_cnt++; end
          else bbeat++;
        end
        if (BVALID && BREADY) begin
          b_cnt++;
          in_flight = 0;
          if (b_cnt == err_burst) begin err_before = ERR; err_pend = 1; end
        end
        if (DONE) begin
          done_cnt++;
          if (!(BVALID && BREADY) || b_cnt != NB) done_errs++;
          done_pend = 1;
        end
        prev_awv  = AWVALID;
        prev_awhs = AWVALID && AWREADY;
        prev_addr = AWADDR;
        BRESP = (err_burst != 0 && wl_cnt == err_burst) ? 2'b10 : 2'b00;
      end
      FIFODATA = $urandom;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_awvalid"}, 32'(AWVALID), 32'd0);
    chk({tag, "_wvalid"},  32'(WVALID),  32'd0);
    chk({tag, "_wlast"},   32'(WLAST),   32'd0);
    chk({tag, "_bready"},  32'(BREADY),  32'd0);
    chk({tag, "_fiford"},  32'(FIFORD),  32'd0);
    chk({tag, "_busy"},    32'(BUSY),    32'd0);
    chk({tag, "_done"},    32'(DONE),    32'd0);
    chk({tag, "_err"},     32'(ERR),     32'd0);
    chk({tag, "_awaddr"},  AWADDR,       32'd0);
  endtask

  task automatic start_frame(input logic [29:0] a, input logic on, input logic st,
                             input int eb, output bit got_busy);
    CAPSTART = 1'b0;
    CAPADDR  = a;
    CAPON    = on;
    repeat (4) wait_cyc();
    reset_mon();
    exp_base  = a;
    stall_en  = st;
    err_burst = eb;
    CAPSTART  = 1'b1;
    got_busy  = 0;
    for (int k = 0; k < 8; k++) begin
      wait_cyc();
      if (BUSY) got_busy = 1;
    end
    CAPSTART = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit to;
    to = 1;
    for (int k = 0; k < 20000; k++) begin
      if (!BUSY) begin to = 0; break; end
      wait_cyc();
    end
    chk({tag, "_timeout"}, 32'(to), 32'd0);
  endtask

  task automatic chk_frame(input string tag, input int nb);
    chk({tag, "_bursts"},   aw_cnt,     nb);
    chk({tag, "_beats"},    beats,      nb * 32);
    chk({tag, "_fiford"},   fiford_cnt, beats);
    chk({tag, "_done"},     done_cnt,   (nb == NB) ? 1 : 0);
    chk({tag, "_addrseq"},  addr_errs,  0);
    chk({tag, "_awstable"}, stab_errs,  0);
    chk({tag, "_wlast"},    wlast_errs, 0);
    chk({tag, "_wearly"},   wv_errs,    0);
    chk({tag, "_outst"},    outst_errs, 0);
    chk({tag, "_wdata"},    wdata_errs, 0);
    chk({tag, "_donepos"},  done_errs,  0);
  endtask

  initial begin
    bit gb;
    int viol;
    bit to;

    vecs[0] = '{30'h1000_0000, 1'b1, 1'b0, 0, 8, 32'h1000_0000, 32'h1000_0380, 256, 1, 1'b0};
    vecs[1] = '{30'h1000_0000, 1'b0, 1'b0, 0, 0, 32'h0,         32'h0,         0,   0, 1'b0};
    vecs[2] = '{30'h0000_0400, 1'b1, 1'b1, 0, 8, 32'h0000_0400, 32'h0000_0780, 256, 1, 1'b0};
    vecs[3] = '{30'h2000_0000, 1'b1, 1'b0, 3, 8, 32'h2000_0000, 32'h2000_0380, 256, 1, 1'b1};
    vecs[4] = '{30'h0123_4000, 1'b0, 1'b0, 0, 0, 32'h0,         32'h0,         0,   0, 1'b1};
    vecs[5] = '{30'h3FFF_FF00, 1'b1, 1'b1, 0, 8, 32'h3FFF_FF00, 32'h0000_0280, 256, 1, 1'b0};

    ARST = 1'b1; CAPSTART = 1'b0; CAPON = 1'b1; CAPADDR = '0;
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
    FIFOREADY = 1'b1; FIFODATA = '0;
    reset_mon();
    repeat (3) wait_cyc();
    chk_reset("rst");
    chk("awlen", 32'(AWLEN), 32'd31);
    chk("awsize_burst_strb", {21'd0, AWSIZE, AWBURST, WSTRB}, {21'd0, 3'b010, 2'b01, 4'hF});
    ARST = 1'b0;
    wait_cyc();

    for (int i = 0; i < 6; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      start_frame(vecs[i].capaddr, vecs[i].capon, vecs[i].stall, vecs[i].err_burst, gb);
      wait_idle(t);
      chk({t, "_busyseen"}, 32'(gb), 32'(vecs[i].capon));
      chk({t, "_awvseen"}, 32'(awv_any), 32'(vecs[i].capon));
      chk({t, "_bursts"}, aw_cnt, vecs[i].exp_bursts);
      chk({t, "_beats"}, beats, vecs[i].exp_beats);
      chk({t, "_fiford"}, fiford_cnt, vecs[i].exp_beats);
      chk({t, "_done"}, done_cnt, vecs[i].exp_done);
      chk({t, "_err"}, 32'(ERR), 32'(vecs[i].exp_err));
      chk({t, "_addrseq"}, addr_errs, 0);
      chk({t, "_awstable"}, stab_errs, 0);
      chk({t, "_wlast"}, wlast_errs, 0);
      chk({t, "_wearly"}, wv_errs, 0);
      chk({t, "_outst"}, outst_errs, 0);
      chk({t, "_wdata"}, wdata_errs, 0);
      chk({t, "_donepos"}, done_errs, 0);
      if (vecs[i].exp_bursts > 0) begin
        chk({t, "_first"}, first_addr, vecs[i].exp_first);
        chk({t, "_last"}, last_addr, vecs[i].exp_last);
      end
      if (vecs[i].err_burst != 0) begin
        chk({t, "_err_before"}, 32'(err_before), 32'd0);
        chk({t, "_err_after"}, 32'(err_after), 32'd1);
      end
      if (!vecs[i].stall && vecs[i].exp_bursts >= 2)
        chk({t, "_period"}, aw_cyc[1] - aw_cyc[0], 35);
    end
    stall_en = 1'b0;

    // FIFO not ready for 50 cycles after the first burst's data phase.
    start_frame(30'h0050_0000, 1'b1, 1'b0, 0, gb);
    to = 1;
    for (int k = 0; k < 200; k++) begin
      if (wl_cnt >= 1) begin to = 0; break; end
      wait_cyc();
    end
    chk("fifo_reach", 32'(to), 32'd0);
    FIFOREADY = 1'b0;
    viol = 0;
    repeat (50) begin
      wait_cyc();
      if (AWVALID || !BUSY) viol++;
    end
    chk("fifo_hold_viol", viol, 0);
    chk("fifo_hold_bursts", aw_cnt, 1);
    FIFOREADY = 1'b1;
    wait_idle("fifo");
    chk_frame("fifo", NB);
    chk("fifo_first", first_addr, 32'h0050_0000);

    // Reset during the 10th beat of burst 5, then restart from CAPADDR.
    start_frame(30'h0ABC_0000, 1'b1, 1'b0, 0, gb);
    to = 1;
    for (int k = 0; k < 2000; k++) begin
      if (beats >= 4 * 32 + 10) begin to = 0; break; end
      wait_cyc();
    end
    chk("arst_reach", 32'(to), 32'd0);
    chk("arst_pre_burst", aw_cnt, 5);
    ARST = 1'b1;
    wait_cyc();
    chk_reset("arst");
    ARST = 1'b0;
    start_frame(30'h0ABC_0000, 1'b1, 1'b0, 0, gb);
    chk("arst_restart_busy", 32'(gb), 32'd1);
    wait_idle("arst");
    chk_frame("arst", NB);
    chk("arst_first", first_addr, 32'h0ABC_0000);
    chk("arst_last", last_addr, 32'h0ABC_0380);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
